regfile_mp_scoreboard: RTL and testbench
========================================

Name: regfile_mp_scoreboard

Overview:
- Parametrised multi-port integer register file for the next-generation RV32 core. Generalises the single-cycle register file to N read ports, M write ports and configurable width and depth.
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard for an issue stage with multi-cycle producers.
- Sits between decode/issue (read, alloc) and writeback (write).

Parameters:
- XLEN, 32, data width of each register in bits.
- DEPTH, 32, number of registers; power of two, minimum 2; AW = $clog2(DEPTH).
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
- SP_IDX, 2, index loaded with SP_INIT at reset.
- SP_INIT, 32'h2ffc, stack-pointer reset value (truncated or zero-extended to XLEN).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rs_addr  input  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW].
- rs_dout  output  NUM_RD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]; combinational.
- rs_busy  output  NUM_RD  1 = register on read port k has a pending producer; combinational.
- wr_en  input  NUM_WR  write enable per write port (RegWrite).
- wr_addr  input  NUM_WR*AW  destination address per write port.
- wr_data  input  NUM_WR*XLEN  write data per write port.
- alloc_en  input  1  mark alloc_rd busy (instruction issued to a multi-cycle unit).
- alloc_rd  input  AW  register to mark busy.
- busy_vec  output  DEPTH  registered scoreboard bits; bit 0 is always 0.

Behaviour:
- Storage: DEPTH x XLEN registers plus a DEPTH-bit busy vector.
- Reset (reset=1 at posedge):
  - All registers are cleared to 0; register SP_IDX is loaded with SP_INIT.
  - busy_vec is cleared to 0.
  - Reset overrides any writes or alloc presented in the same cycle.
  - Reset asserted mid-operation discards all pending busy state.
- Register 0: reads always return 0; writes to it are ignored; alloc to it is ignored; busy bit 0 stays 0.
- Write (registered, one cycle):
  - On posedge with wr_en[j]=1 and wr_addr[j]!=0, reg[wr_addr[j]] <= wr_data[j].
  - When two or more enabled ports target the same address, the highest-indexed port wins.
  - Writes to distinct addresses all commit in the same cycle.
- Read (combinational, zero latency):
  - BYPASS=0: rs_dout[k] = stored reg[rs_addr[k]].
  - BYPASS=1: if any enabled write port targets rs_addr[k] (and the address is nonzero) this cycle, rs_dout[k] is that port's wr_data, using highest-port priority. Otherwise it returns the stored value.
- Scoreboard (registered):
  - A write to register r clears busy[r] at the posedge.
  - alloc_en=1 sets busy[alloc_rd] at the posedge.
  - Alloc and write to the same register in the same cycle leave busy=1 (a new producer supersedes the old one).
  - Alloc and write to different registers apply independently.
  - Writes to a non-busy register are legal; data updates and busy stays 0.
  - Alloc of an already-busy register is legal; busy stays 1.
- rs_busy[k]:
  - BYPASS=0: rs_busy[k] = busy[rs_addr[k]].
  - BYPASS=1: rs_busy[k] = busy[rs_addr[k]] AND NOT (an enabled write to rs_addr[k] this cycle). Data is forwarded, so the consumer need not stall.
  - Same-cycle alloc never affects rs_busy or rs_dout.
- No X propagation: all outputs are defined after the first reset cycle.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Test Plan:
- Reset with wr_en=2'b11 asserted -> next cycle, all reads return 0 except reg 2 = 32'h00002ffc; busy_vec = 0; writes are dropped.
- Write reg 0 = 32'hdeadbeef via port 0, with alloc_rd=0 -> reg 0 reads 0 and busy_vec[0] = 0.
- Both ports write reg 5 (port0 = 32'h11, port1 = 32'h22) in the same cycle -> reg 5 = 32'h22; with BYPASS=1, same-cycle read of reg 5 returns 32'h22; with BYPASS=0 it returns the old value.
- Alloc reg 7 -> rs_busy=1 next cycle. Write reg 7 = 32'h55 -> same-cycle rs_busy=0 and rs_dout=32'h55 (BYPASS=1). busy_vec[7]=0 afterwards.
- Alloc reg 9 and write reg 9 in the same cycle -> busy_vec[9]=1 and reg 9 holds the written data.
- Alloc regs 3, 4, 6 over successive cycles, then assert reset -> busy_vec=0 and reg 3 = 0 on the next cycle.

Source files
------------

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with optional same-cycle write-to-read
// bypass and a per-register busy scoreboard for multi-cycle producers.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset
//   rs_addr   - NUM_RD packed read addresses (port k at [k*AW +: AW])
//   rs_dout   - NUM_RD packed read data (combinational)
//   rs_busy   - per read port: register has a pending producer (combinational)
//   wr_en     - per write port enable
//   wr_addr   - NUM_WR packed destination addresses
//   wr_data   - NUM_WR packed write data
//   alloc_en  - mark alloc_rd busy at the next edge
//   alloc_rd  - register to mark busy
//   busy_vec  - registered scoreboard bits, bit 0 always 0
module regfile_mp_scoreboard #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h2ffc,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rs_addr,
  output logic [NUM_RD*XLEN-1:0]   rs_dout,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_rd,
  output logic [DEPTH-1:0]         busy_vec
);

  localparam logic [XLEN-1:0] SP_VAL = XLEN'(SP_INIT);

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy_next;

  // Scoreboard update: writes clear, alloc sets afterwards so a new producer wins.
  always_comb begin
    busy_next = busy_vec;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en) begin
      busy_next[alloc_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Storage and scoreboard state; later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX && SP_IDX != 0) ? SP_VAL : '0;
      end
      busy_vec <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
      busy_vec <= busy_next;
    end
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rd;
  logic            fwd;

  // Read ports with optional forwarding; a forwarded read never reports busy.
  always_comb begin
    rs_dout = '0;
    rs_busy = '0;
    ra      = '0;
    rd      = '0;
    fwd     = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra  = rs_addr[k*AW +: AW];
      rd  = (ra == '0) ? '0 : regs[ra];
      fwd = 1'b0;
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && ra != '0 && wr_addr[j*AW +: AW] == ra) begin
            rd  = wr_data[j*XLEN +: XLEN];
            fwd = 1'b1;
          end
        end
      end
      rs_dout[k*XLEN +: XLEN] = rd;
      rs_busy[k]              = busy_vec[ra] & ~fwd;
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: one instance with bypass, one
// without, sharing all inputs.
module tb_regfile_mp_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rs_addr;
  logic [63:0] rs_dout_b, rs_dout_n;
  logic [1:0]  rs_busy_b, rs_busy_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic [31:0] busy_vec_b, busy_vec_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_scoreboard #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_dout(rs_dout_b),
    .rs_busy(rs_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .busy_vec(busy_vec_b)
  );

  regfile_mp_scoreboard #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_dout(rs_dout_n),
    .rs_busy(rs_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .busy_vec(busy_vec_n)
  );

  task automatic idle();
    wr_en    = 2'b00;
    wr_addr  = '0;
    wr_data  = '0;
    alloc_en = 1'b0;
    alloc_rd = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset    = 1'b1;
    rs_addr  = '0;
    idle();
    wr_en    = 2'b11;
    wr_addr  = {5'd4, 5'd3};
    wr_data  = {32'haaaa_0004, 32'haaaa_0003};
    alloc_en = 1'b1;
    alloc_rd = 5'd8;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    total++;
    if (busy_vec_b !== 32'h0) begin
      bad++; $display("FAIL reset_busy_vec got=%h exp=%h", busy_vec_b, 32'h0);
    end
    for (int r = 0; r < 32; r++) begin
      rs_addr = {5'd0, 5'(r)};
      exp = (r == 2) ? 32'h0000_2ffc : 32'h0;
      #1;
      total++;
      if (rs_dout_b[31:0] !== exp || rs_dout_n[31:0] !== exp) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h/%h exp=%h", r, rs_dout_b[31:0], rs_dout_n[31:0], exp);
      end
    end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd0};
    wr_data  = {32'h0, 32'hdead_beef};
    alloc_en = 1'b1;
    alloc_rd = 5'd0;
    rs_addr  = {5'd0, 5'd0};
    #1;
    total++;
    if (rs_dout_b[31:0] !== 32'h0 || rs_busy_b[0] !== 1'b0) begin
      bad++; $display("FAIL reg0_same_cycle got=%h busy=%b exp=0", rs_dout_b[31:0], rs_busy_b[0]);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (rs_dout_b[31:0] !== 32'h0 || rs_dout_n[31:0] !== 32'h0) begin
      bad++; $display("FAIL reg0_read got=%h/%h exp=0", rs_dout_b[31:0], rs_dout_n[31:0]);
    end
    total++;
    if (busy_vec_b !== 32'h0) begin
      bad++; $display("FAIL reg0_busy got=%h exp=0", busy_vec_b);
    end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'h77};
    @(negedge clk);
    wr_en   = 2'b11;
    wr_addr = {5'd5, 5'd5};
    wr_data = {32'h22, 32'h11};
    rs_addr = {5'd0, 5'd5};
    #1;
    total++;
    if (rs_dout_b[31:0] !== 32'h22) begin
      bad++; $display("FAIL same_addr_bypass got=%h exp=%h", rs_dout_b[31:0], 32'h22);
    end
    total++;
    if (rs_dout_n[31:0] !== 32'h77) begin
      bad++; $display("FAIL same_addr_nobypass got=%h exp=%h", rs_dout_n[31:0], 32'h77);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (rs_dout_b[31:0] !== 32'h22 || rs_dout_n[31:0] !== 32'h22) begin
      bad++; $display("FAIL same_addr_commit got=%h/%h exp=%h", rs_dout_b[31:0], rs_dout_n[31:0], 32'h22);
    end
  endtask

  task automatic test_alloc_write();
    @(negedge clk);
    alloc_en = 1'b1;
    alloc_rd = 5'd7;
    rs_addr  = {5'd7, 5'd0};
    #1;
    total++;
    if (rs_busy_b[1] !== 1'b0) begin
      bad++; $display("FAIL alloc_same_cycle_busy got=%b exp=0", rs_busy_b[1]);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (rs_busy_b[1] !== 1'b1 || rs_busy_n[1] !== 1'b1 || busy_vec_b[7] !== 1'b1) begin
      bad++; $display("FAIL alloc7_busy got=%b/%b/%b exp=1", rs_busy_b[1], rs_busy_n[1], busy_vec_b[7]);
    end
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd7};
    wr_data = {32'h0, 32'h55};
    #1;
    total++;
    if (rs_busy_b[1] !== 1'b0 || rs_dout_b[63:32] !== 32'h55) begin
      bad++; $display("FAIL write7_bypass got busy=%b data=%h exp busy=0 data=55", rs_busy_b[1], rs_dout_b[63:32]);
    end
    total++;
    if (rs_busy_n[1] !== 1'b1 || rs_dout_n[63:32] !== 32'h0) begin
      bad++; $display("FAIL write7_nobypass got busy=%b data=%h exp busy=1 data=0", rs_busy_n[1], rs_dout_n[63:32]);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (busy_vec_b[7] !== 1'b0 || busy_vec_n[7] !== 1'b0 || rs_dout_n[63:32] !== 32'h55) begin
      bad++; $display("FAIL write7_after got busy=%b/%b data=%h exp 0/0/55", busy_vec_b[7], busy_vec_n[7], rs_dout_n[63:32]);
    end
  endtask

  task automatic test_alloc_and_write();
    @(negedge clk);
    alloc_en = 1'b1;
    alloc_rd = 5'd9;
    wr_en    = 2'b10;
    wr_addr  = {5'd9, 5'd0};
    wr_data  = {32'h99, 32'h0};
    @(negedge clk);
    alloc_en = 1'b1;
    alloc_rd = 5'd10;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd11};
    wr_data  = {32'h0, 32'hbb};
    @(negedge clk);
    idle();
    rs_addr = {5'd11, 5'd9};
    #1;
    total++;
    if (busy_vec_b !== 32'h0000_0600 || busy_vec_n !== 32'h0000_0600) begin
      bad++; $display("FAIL alloc_write_busy got=%h/%h exp=%h", busy_vec_b, busy_vec_n, 32'h600);
    end
    total++;
    if (rs_dout_b !== {32'hbb, 32'h99} || rs_busy_b !== 2'b01) begin
      bad++; $display("FAIL alloc_write_data got=%h busy=%b exp=%h busy=01", rs_dout_b, rs_busy_b, {32'hbb, 32'h99});
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wr_en   = 2'b11;
    wr_addr = {5'd13, 5'd12};
    wr_data = {32'hbbbb_0013, 32'haaaa_0012};
    @(negedge clk);
    wr_addr = {5'd12, 5'd14};
    wr_data = {32'hcccc_0012, 32'hdddd_0014};
    @(negedge clk);
    idle();
    rs_addr = {5'd13, 5'd12};
    #1;
    total++;
    if (rs_dout_n !== {32'hbbbb_0013, 32'hcccc_0012}) begin
      bad++; $display("FAIL b2b_12_13 got=%h exp=%h", rs_dout_n, {32'hbbbb_0013, 32'hcccc_0012});
    end
    rs_addr = {5'd31, 5'd14};
    #1;
    total++;
    if (rs_dout_b !== {32'h0, 32'hdddd_0014}) begin
      bad++; $display("FAIL b2b_14 got=%h exp=%h", rs_dout_b, {32'h0, 32'hdddd_0014});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alloc_en = 1'b1;
    alloc_rd = 5'd3;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd3};
    wr_data  = {32'h0, 32'h33};
    @(negedge clk);
    wr_en    = 2'b00;
    alloc_rd = 5'd4;
    @(negedge clk);
    alloc_rd = 5'd6;
    @(negedge clk);
    idle();
    rs_addr = {5'd4, 5'd3};
    #1;
    total++;
    if (busy_vec_b !== 32'h0000_0658 || rs_dout_b[31:0] !== 32'h33) begin
      bad++; $display("FAIL pre_reset got busy=%h r3=%h exp busy=658 r3=33", busy_vec_b, rs_dout_b[31:0]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0 || rs_busy_b !== 2'b00) begin
      bad++; $display("FAIL mid_reset_busy got=%h/%h rs=%b exp=0", busy_vec_b, busy_vec_n, rs_busy_b);
    end
    total++;
    if (rs_dout_b !== 64'h0 || rs_dout_n !== 64'h0) begin
      bad++; $display("FAIL mid_reset_r3 got=%h/%h exp=0", rs_dout_b, rs_dout_n);
    end
    rs_addr = {5'd5, 5'd2};
    #1;
    total++;
    if (rs_dout_b !== {32'h0, 32'h0000_2ffc}) begin
      bad++; $display("FAIL mid_reset_sp got=%h exp=%h", rs_dout_b, {32'h0, 32'h0000_2ffc});
    end
  endtask

  initial begin
    test_reset();
    test_reg0();
    test_same_addr();
    test_alloc_write();
    test_alloc_and_write();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
